// File: rtl/crossbar_nxm_buffered.sv
// crossbar_nxm_buffered: N_INPUTS x N_OUTPUTS val/rdy crossbar with a
// one-entry register on every output (1-cycle latency, 1 msg/cycle/output).
// Each output has its own input select and enable, so one input can fan out
// to several outputs. A fan-out transfer is atomic: all selected outputs load
// on the same edge, or none do.
//
// Control word layout (output 0 at the MSBs):
//   sel[o] = control[CONTROL_BIT_WIDTH-1-o*SEL_W -: SEL_W],  SEL_W = $clog2(N_INPUTS)
//   en[o]  = control[o]
//   A select >= N_INPUTS acts as a disabled output.
//   CONTROL_BIT_WIDTH must be >= N_OUTPUTS*(SEL_W+1).
// A new control word is accepted only once every output register is empty.
// While outputs drain for a pending control word (DRAIN), inputs are stalled.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   recv_msg/val/rdy  N_INPUTS input channels (recv_rdy is combinational)
//   send_msg/val/rdy  N_OUTPUTS output channels (send_msg/send_val registered)
//   control/_val/_rdy routing configuration handshake (control_rdy combinational)
//   xfer_count        saturating count of accepted input messages, cleared on
//                     each accepted control word; present only when the macro
//                     XBAR_XFER_COUNT_EN is defined
module crossbar_nxm_buffered #(
   parameter int unsigned                  BIT_WIDTH         = 32,
   parameter int unsigned                  N_INPUTS          = 4,
   parameter int unsigned                  N_OUTPUTS         = 4,
   parameter int unsigned                  CONTROL_BIT_WIDTH = 32,
   parameter logic [CONTROL_BIT_WIDTH-1:0] RESET_CONTROL     = '0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [N_INPUTS-1:0][BIT_WIDTH-1:0]   recv_msg,
   input  logic [N_INPUTS-1:0]                  recv_val,
   output logic [N_INPUTS-1:0]                  recv_rdy,
   output logic [N_OUTPUTS-1:0][BIT_WIDTH-1:0]  send_msg,
   output logic [N_OUTPUTS-1:0]                 send_val,
   input  logic [N_OUTPUTS-1:0]                 send_rdy,
   input  logic [CONTROL_BIT_WIDTH-1:0]         control,
   input  logic                                 control_val,
`ifdef XBAR_XFER_COUNT_EN
   output logic [31:0]                          xfer_count,
`endif
   output logic                                 control_rdy
);

   localparam int unsigned SEL_W = $clog2(N_INPUTS);
   localparam logic [SEL_W:0] N_IN_L = (SEL_W+1)'(N_INPUTS);

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   logic [0:0]                         state_q, state_d;
   logic [CONTROL_BIT_WIDTH-1:0]       ctrl_q, ctrl_d;
   logic [N_OUTPUTS-1:0]               send_val_q, send_val_d;
   logic [N_OUTPUTS-1:0][BIT_WIDTH-1:0] send_msg_q, send_msg_d;

   logic [N_OUTPUTS-1:0][SEL_W-1:0]    sel_c;
   logic [N_OUTPUTS-1:0]               en_c;
   logic [N_OUTPUTS-1:0]               can_load_c;
   logic [N_OUTPUTS-1:0]               load_c;
   logic [N_INPUTS-1:0]                hit_c;
   logic [N_INPUTS-1:0]                blocked_c;
   logic [N_INPUTS-1:0]                xfer_c;
   logic                               any_val_c;
   logic                               ctrl_accept_c;
   logic                               unused_ctrl_c;

   // Only the select fields and enable bits of the stored control are used.
   assign unused_ctrl_c = ^ctrl_q;

   // Decode stored control; out-of-range selects count as disabled.
   always_comb begin
      sel_c = '0;
      en_c  = '0;
      for (int o = 0; o < int'(N_OUTPUTS); o++) begin
         sel_c[o] = ctrl_q[CONTROL_BIT_WIDTH-1-o*SEL_W -: SEL_W];
         en_c[o]  = ctrl_q[o] & ({1'b0, sel_c[o]} < N_IN_L);
      end
   end

   assign any_val_c  = |send_val_q;
   assign can_load_c = ~send_val_q | send_rdy;

   // An input is ready only if every output selecting it can take data now.
   always_comb begin
      hit_c     = '0;
      blocked_c = '0;
      for (int i = 0; i < int'(N_INPUTS); i++) begin
         for (int o = 0; o < int'(N_OUTPUTS); o++) begin
            if (en_c[o] && (sel_c[o] == SEL_W'(i))) begin
               hit_c[i] = 1'b1;
               if (!can_load_c[o]) begin
                  blocked_c[i] = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      recv_rdy = '0;
      if (reset && (state_q == ST_RUN) && !control_val) begin
         recv_rdy = hit_c & ~blocked_c;
      end
   end

   assign xfer_c = recv_val & recv_rdy;

   // Never high while any output holds data, so control swaps only when empty.
   assign control_rdy   = reset & ~any_val_c;
   assign ctrl_accept_c = control_val & control_rdy;

   // Output register next state: load from the selected input, else drain/hold.
   always_comb begin
      load_c     = '0;
      send_msg_d = send_msg_q;
      for (int o = 0; o < int'(N_OUTPUTS); o++) begin
         for (int i = 0; i < int'(N_INPUTS); i++) begin
            if (en_c[o] && (sel_c[o] == SEL_W'(i)) && xfer_c[i]) begin
               load_c[o]     = 1'b1;
               send_msg_d[o] = recv_msg[i];
            end
         end
      end
      send_val_d = load_c | (send_val_q & ~send_rdy);
   end

   // Control FSM next state.
   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      case (state_q)
         ST_RUN: begin
            if (control_val) begin
               if (any_val_c) begin
                  state_d = ST_DRAIN;
               end else begin
                  ctrl_d = control;
               end
            end
         end
         ST_DRAIN: begin
            if (!any_val_c) begin
               state_d = ST_RUN;
               if (control_val) begin
                  ctrl_d = control;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         ctrl_q     <= RESET_CONTROL;
         send_val_q <= '0;
         send_msg_q <= '0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         send_val_q <= send_val_d;
         send_msg_q <= send_msg_d;
      end
   end

   assign send_val = send_val_q;
   assign send_msg = send_msg_q;

`ifdef XBAR_XFER_COUNT_EN
   localparam int unsigned CNT_W = $clog2(N_INPUTS + 1);

   logic [31:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0] pop_c;
   logic [32:0]      sum_c;

   // One count per accepted input message, independent of fan-out.
   always_comb begin
      pop_c = '0;
      for (int i = 0; i < int'(N_INPUTS); i++) begin
         pop_c = pop_c + CNT_W'(xfer_c[i]);
      end
      sum_c = 33'(cnt_q) + 33'(pop_c);
      if (ctrl_accept_c) begin
         cnt_d = '0;
      end else if (sum_c[32]) begin
         cnt_d = '1;
      end else begin
         cnt_d = sum_c[31:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign xfer_count = cnt_q;
`else
   logic unused_accept_c;
   assign unused_accept_c = ctrl_accept_c;
`endif

endmodule

// File: tb/tb_crossbar_nxm_buffered.sv
// Scoreboard bench for crossbar_nxm_buffered (4x4, 32-bit).
// Stimulus pushes expected words per output; a negedge monitor pops and
// compares each time an output handshakes.
module tb_crossbar_nxm_buffered;

   localparam int unsigned BW  = 32;
   localparam int unsigned NI  = 4;
   localparam int unsigned NO  = 4;
   localparam int unsigned CBW = 32;

   logic                  clk;
   logic                  reset;
   logic [NI-1:0][BW-1:0] recv_msg;
   logic [NI-1:0]         recv_val;
   logic [NI-1:0]         recv_rdy;
   logic [NO-1:0][BW-1:0] send_msg;
   logic [NO-1:0]         send_val;
   logic [NO-1:0]         send_rdy;
   logic [CBW-1:0]        control;
   logic                  control_val;
   logic                  control_rdy;
`ifdef XBAR_XFER_COUNT_EN
   logic [31:0]           xfer_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q [4][$];
   logic [31:0] exp_d;
   logic [CBW-1:0] cur_ctrl;

   crossbar_nxm_buffered #(
      .BIT_WIDTH(BW), .N_INPUTS(NI), .N_OUTPUTS(NO),
      .CONTROL_BIT_WIDTH(CBW), .RESET_CONTROL('0)
   ) dut (
      .clk(clk), .reset(reset),
      .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
      .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
      .control(control), .control_val(control_val),
`ifdef XBAR_XFER_COUNT_EN
      .xfer_count(xfer_count),
`endif
      .control_rdy(control_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Control word: sel fields for outputs 0..3 at the MSBs, enables at bits 3:0.
   function automatic logic [31:0] mk_ctrl(input logic [1:0] s0, input logic [1:0] s1,
                                           input logic [1:0] s2, input logic [1:0] s3,
                                           input logic [3:0] en);
      return {s0, s1, s2, s3, 20'h0, en};
   endfunction

   // Outputs that receive a message from input i under control c.
   function automatic logic [3:0] routes(input logic [31:0] c, input int i);
      logic [3:0] r;
      logic [1:0] s;
      r = '0;
      for (int o = 0; o < 4; o++) begin
         s = c[31-2*o -: 2];
         if (c[o] && (int'(s) == i)) r[o] = 1'b1;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present d on input i until accepted; records the expected fan-out.
   task automatic xfer(input int i, input logic [31:0] d);
      logic [3:0] r;
      bit ok;
      ok = 1'b0;
      recv_msg[i] = d;
      recv_val[i] = 1'b1;
      for (int n = 0; n < 100; n++) begin
         #1;
         if (recv_rdy[i]) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL xfer_timeout input %0d got rdy 0 expected 1", i);
      end else begin
         r = routes(cur_ctrl, i);
         for (int o = 0; o < 4; o++) if (r[o]) exp_q[o].push_back(d);
      end
      @(posedge clk);
      #1;
      recv_val[i] = 1'b0;
   endtask

   task automatic set_ctrl(input logic [31:0] c);
      bit ok;
      ok = 1'b0;
      control     = c;
      control_val = 1'b1;
      for (int n = 0; n < 100; n++) begin
         #1;
         if (control_rdy) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ctrl_timeout got control_rdy 0 expected 1");
      end
      @(posedge clk);
      #1;
      control_val = 1'b0;
      cur_ctrl    = c;
   endtask

   // Scoreboard monitor: compare every output handshake against the queue.
   always @(negedge clk) begin
      if (reset) begin
         for (int o = 0; o < 4; o++) begin
            if (send_val[o] && send_rdy[o]) begin
               checks++;
               if (exp_q[o].size() == 0) begin
                  errors++;
                  $display("FAIL sb_out%0d got %h expected no message", o, send_msg[o]);
               end else begin
                  exp_d = exp_q[o].pop_front();
                  if (send_msg[o] !== exp_d) begin
                     errors++;
                     $display("FAIL sb_out%0d got %h expected %h", o, send_msg[o], exp_d);
                  end
               end
            end
         end
         checks++;
         if (control_rdy && (|send_val)) begin
            errors++;
            $display("FAIL ctrl_rdy_while_valid got control_rdy 1 expected 0 (send_val %b)", send_val);
         end
      end
   end

   initial begin
      reset       = 1'b0;
      recv_msg    = '0;
      recv_val    = '0;
      send_rdy    = '0;
      control     = '0;
      control_val = 1'b0;
      cur_ctrl    = '0;

      // Reset state.
      #3;
      chk("rst_recv_rdy", 32'(recv_rdy), 32'h0);
      chk("rst_control_rdy", 32'(control_rdy), 32'h0);
      chk("rst_send_val", 32'(send_val), 32'h0);
      chk("rst_send_msg0", send_msg[0], 32'h0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("post_rst_recv_rdy", 32'(recv_rdy), 32'h0);
`ifdef XBAR_XFER_COUNT_EN
      chk("cnt_reset", xfer_count, 32'h0);
`endif

      // Basic routing: sel=[2,0,3,1], all enabled; input 2 -> output 0.
      tick();
      set_ctrl(mk_ctrl(2'd2, 2'd0, 2'd3, 2'd1, 4'hF));
      xfer(2, 32'hA5A5A5A5);
      chk("basic_send_val", 32'(send_val), 32'h1);
      chk("basic_send_msg0", send_msg[0], 32'hA5A5A5A5);
      send_rdy = 4'hF;
      tick();
      chk("basic_drained", 32'(send_val), 32'h0);

      // Broadcast: input 1 -> outputs 0 and 3, atomic under back-pressure.
      send_rdy = 4'h0;
      set_ctrl(mk_ctrl(2'd1, 2'd0, 2'd0, 2'd1, 4'b1001));
      xfer(1, 32'h1111);
      #1;
      chk("bcast_full_rdy", 32'(recv_rdy[1]), 32'h0);
      send_rdy = 4'b0001;
      recv_msg[1] = 32'h1234;
      recv_val[1] = 1'b1;
      #1;
      chk("bcast_blocked_rdy", 32'(recv_rdy[1]), 32'h0);
      tick();
      chk("bcast_partial_val", 32'(send_val), 32'h8);
      chk("bcast_still_blocked", 32'(recv_rdy[1]), 32'h0);
      send_rdy = 4'b1001;
      #1;
      chk("bcast_released_rdy", 32'(recv_rdy[1]), 32'h1);
      exp_q[0].push_back(32'h1234);
      exp_q[3].push_back(32'h1234);
      tick();
      recv_val[1] = 1'b0;
      chk("bcast_val", 32'(send_val), 32'h9);
      chk("bcast_msg0", send_msg[0], 32'h1234);
      chk("bcast_msg3", send_msg[3], 32'h1234);
      tick();
      chk("bcast_drained", 32'(send_val), 32'h0);

      // Throughput: input 0 -> output 1, one word per cycle.
      set_ctrl(mk_ctrl(2'd0, 2'd0, 2'd0, 2'd0, 4'b0010));
      send_rdy = 4'hF;
      for (int k = 0; k < 8; k++) begin
         recv_msg[0] = 32'(k);
         recv_val[0] = 1'b1;
         #1;
         chk("tput_rdy", 32'(recv_rdy[0]), 32'h1);
         exp_q[1].push_back(32'(k));
         tick();
         chk("tput_val", 32'(send_val), 32'h2);
         chk("tput_msg", send_msg[1], 32'(k));
      end
      recv_val[0] = 1'b0;
      tick();

      // Reconfiguration under load: output 2 full and stalled.
      set_ctrl(mk_ctrl(2'd0, 2'd0, 2'd3, 2'd0, 4'b0100));
      send_rdy = 4'h0;
      xfer(3, 32'hBEEF);
      control     = mk_ctrl(2'd0, 2'd3, 2'd0, 2'd0, 4'b0010);
      control_val = 1'b1;
      recv_msg[3] = 32'hCAFE;
      recv_val[3] = 1'b1;
      #1;
      chk("reconf_ctrl_rdy_busy", 32'(control_rdy), 32'h0);
      chk("reconf_recv_rdy_req", 32'(recv_rdy), 32'h0);
      tick();
      chk("drain_recv_rdy", 32'(recv_rdy), 32'h0);
      chk("drain_ctrl_rdy", 32'(control_rdy), 32'h0);
      send_rdy = 4'b0100;
      #1;
      chk("drain_ctrl_rdy_pre", 32'(control_rdy), 32'h0);
      tick();
      chk("drain_ctrl_rdy_done", 32'(control_rdy), 32'h1);
      chk("drain_recv_rdy_done", 32'(recv_rdy), 32'h0);
      chk("drain_send_val", 32'(send_val), 32'h0);
      tick();
      control_val = 1'b0;
      cur_ctrl    = mk_ctrl(2'd0, 2'd3, 2'd0, 2'd0, 4'b0010);
      send_rdy    = 4'h0;
      xfer(3, 32'hCAFE);
      chk("newroute_val", 32'(send_val), 32'h2);
      chk("newroute_msg1", send_msg[1], 32'hCAFE);
      send_rdy = 4'hF;
      tick();

      // Asynchronous reset with a buffered message.
      send_rdy = 4'h0;
      xfer(3, 32'h5555);
      #2;
      reset = 1'b0;
      for (int o = 0; o < 4; o++) exp_q[o].delete();
      #1;
      chk("arst_send_val", 32'(send_val), 32'h0);
      chk("arst_send_msg1", send_msg[1], 32'h0);
      chk("arst_recv_rdy", 32'(recv_rdy), 32'h0);
      chk("arst_ctrl_rdy", 32'(control_rdy), 32'h0);
      tick();
      tick();
      reset    = 1'b1;
      cur_ctrl = '0;
      recv_val = 4'hF;
      #1;
      chk("arst_ctrl_cleared_rdy", 32'(recv_rdy), 32'h0);
      tick();
      chk("arst_no_load", 32'(send_val), 32'h0);
      recv_val = 4'h0;

`ifdef XBAR_XFER_COUNT_EN
      // Transfer counter: one count per accepted message, cleared on control.
      send_rdy = 4'hF;
      set_ctrl(mk_ctrl(2'd1, 2'd2, 2'd0, 2'd1, 4'b1011));
      chk("cnt_after_ctrl", xfer_count, 32'h0);
      xfer(1, 32'h0000_0101);
      xfer(2, 32'h0000_0202);
      xfer(2, 32'h0000_0303);
      chk("cnt_three", xfer_count, 32'h3);
      set_ctrl(mk_ctrl(2'd2, 2'd0, 2'd3, 2'd1, 4'hF));
      chk("cnt_clear", xfer_count, 32'h0);
`endif

      send_rdy = 4'hF;
      tick();
      tick();
      for (int o = 0; o < 4; o++) begin
         chk($sformatf("sb_empty_out%0d", o), 32'(exp_q[o].size()), 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/crossbar_nxm_buffered.md
Name: crossbar_nxm_buffered

Overview:
- Parametrised N_INPUTS x N_OUTPUTS val/rdy crossbar; successor to the single-output blocking crossbar.
- Each output has an independent input select and enable, so one input can broadcast to several outputs.
- Each output has a one-entry output register, giving 1-cycle latency.
- Control reconfiguration is safe: accepted only after all in-flight data drains. Sits between the deserializer/FFT channels and downstream consumers.

Parameters:
- BIT_WIDTH, 32, message width
- N_INPUTS, 4, number of input channels (>=2)
- N_OUTPUTS, 4, number of output channels (>=1)
- CONTROL_BIT_WIDTH, 32, control word width; must be >= N_OUTPUTS*(SEL_W+1), where SEL_W = $clog2(N_INPUTS)
- RESET_CONTROL, 0, value loaded into stored control on reset

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- recv_msg  input  BIT_WIDTH x N_INPUTS  input messages
- recv_val  input  1 x N_INPUTS  input valid
- recv_rdy  output  1 x N_INPUTS  input ready
- send_msg  output  BIT_WIDTH x N_OUTPUTS  registered output messages
- send_val  output  1 x N_OUTPUTS  output valid (registered)
- send_rdy  input  1 x N_OUTPUTS  downstream ready
- control  input  CONTROL_BIT_WIDTH  routing configuration
- control_val  input  1  control valid
- control_rdy  output  1  control ready

Behaviour:
- Control layout:
  - sel[o] = stored_control[CONTROL_BIT_WIDTH-1-o*SEL_W -: SEL_W] (output 0 at the MSBs).
  - en[o] = stored_control[o].
  - A select value >= N_INPUTS behaves as if en[o] = 0.
- Reset (reset=0, async):
  - stored_control=RESET_CONTROL, all send_val=0, send_msg=0, FSM=RUN.
  - Combinational outputs during reset: recv_rdy=0, control_rdy=0.
- Output slot o can load ("can_load[o]") when send_val[o]=0 or send_rdy[o]=1.
- recv_rdy[i] is high only when all of these hold:
  - FSM=RUN and control_val=0;
  - at least one output has en[o]=1 and sel[o]=i;
  - every such output has can_load[o].
- Transfer occurs when recv_val[i] & recv_rdy[i]:
  - Every output selecting i loads send_msg[o]=recv_msg[i] and sets send_val[o]=1 on the next edge (latency 1).
  - Broadcast is atomic: all selecting outputs load together or none do.
- An output that drains (send_val & send_rdy) with no new load clears send_val next edge.
- Drain and load in the same cycle gives back-to-back throughput of 1 msg/cycle per output.
- send_msg holds its value while send_val=0. No combinational path exists from send_rdy to send_val.
- Disabled outputs never assert send_val after their existing entry drains.
- FSM states RUN and DRAIN:
  - RUN, control_val=1, all send_val=0: control_rdy=1, latch control; new routing applies from the next cycle; stay in RUN.
  - RUN, control_val=1, any send_val=1: control_rdy=0, go to DRAIN.
  - DRAIN: all recv_rdy=0; outputs keep draining normally.
  - DRAIN, all send_val=0: control_rdy=1. If control_val=1, latch control and go to RUN. If control_val has dropped, go to RUN without latching.
  - control_rdy is never high while any send_val=1.
- Inputs with no enabled output selecting them hold recv_rdy=0 and are back-pressured, never dropped.
- Reset mid-transfer discards all buffered messages immediately.

Optional Feature:
- Macro XBAR_XFER_COUNT_EN.
- Defined:
  - Adds port xfer_count, output, 32 bits.
  - Counts input transfers (one per accepted recv message, regardless of fan-out).
  - Saturates at 0xFFFFFFFF, resets to 0, and clears to 0 on each accepted control word.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Basic routing, 4x4, control sel=[2,0,3,1] with all enabled: send 0xA5A5A5A5 on input 2 → send_msg[0]=0xA5A5A5A5, send_val[0]=1 exactly 1 cycle later; no other output valid.
- Broadcast: sel[0]=sel[3]=1, both enabled, send_rdy[3]=0 with output 3 full → recv_rdy[1]=0. Raise send_rdy[3] → 0x1234 appears on outputs 0 and 3 on the same edge.
- Throughput: stream 8 words 0..7 into input 0 → output 1 with send_rdy held at 1 → one word per cycle, in order, no bubbles, recv_rdy stays high.
- Reconfiguration under load: output 2 holds data with send_rdy[2]=0, assert control_val → FSM enters DRAIN and all recv_rdy=0. Release send_rdy[2] → control_rdy=1 on the next cycle, new routing observed on the first subsequent message.
- Async reset: assert reset=0 mid-cycle while send_val=1 → send_val drops without waiting for a clock edge. After release, stored_control=RESET_CONTROL (0 → all outputs disabled, all recv_rdy=0).
- With XBAR_XFER_COUNT_EN defined: 3 transfers, one of which is a broadcast to 2 outputs → xfer_count=3. Accept a control word → xfer_count=0.
